alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_decode.sv | 67 ++++++
 rtl/alu_issue.sv | 152 +++++++++++++++
 tb/tb_alu_issue.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue block.
//   - ALU control codes ({funct7[5], funct7[0], funct3} encoding)
//   - RV32 opcode constants
//   - issue FSM state enum and latency class enum
//   - is_rv32i_ctrl(): base-ISA legality of a control code
package alu_pkg;

    localparam logic [4:0] CTRL_ADD    = 5'd0;
    localparam logic [4:0] CTRL_SLL    = 5'd1;
    localparam logic [4:0] CTRL_XOR    = 5'd4;
    localparam logic [4:0] CTRL_SRL    = 5'd5;
    localparam logic [4:0] CTRL_OR     = 5'd6;
    localparam logic [4:0] CTRL_AND    = 5'd7;
    localparam logic [4:0] CTRL_MUL    = 5'd8;
    localparam logic [4:0] CTRL_MULH   = 5'd9;
    localparam logic [4:0] CTRL_MULHSU = 5'd10;
    localparam logic [4:0] CTRL_MULHU  = 5'd11;
    localparam logic [4:0] CTRL_DIV    = 5'd12;
    localparam logic [4:0] CTRL_DIVU   = 5'd13;
    localparam logic [4:0] CTRL_REM    = 5'd14;
    localparam logic [4:0] CTRL_REMU   = 5'd15;
    localparam logic [4:0] CTRL_SUB    = 5'd16;
    localparam logic [4:0] CTRL_SRA    = 5'd21;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        LAT_CLASS_I   = 2'd0,
        LAT_CLASS_MUL = 2'd1,
        LAT_CLASS_DIV = 2'd2
    } lat_class_t;

    function automatic logic is_rv32i_ctrl(input logic [4:0] c);
        case (c)
            CTRL_ADD, CTRL_SLL, CTRL_XOR, CTRL_SRL,
            CTRL_OR, CTRL_AND, CTRL_SUB, CTRL_SRA: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational RV32 instruction decode for the ALU issue block.
// Ports:
//   instr     in  32  instruction word
//   alu_ctrl  out 5   ALU control code
//   use_imm   out 1   operand b comes from imm instead of rs2
//   imm       out 32  sign-extended I-immediate (shamt for shift-immediates)
//   illegal   out 1   instruction cannot be executed by the ALU
//   lat_class out 2   latency class (RV32I / multiply / divide)
// Configuration macro: ALU_ISSUE_M_EXT_EN enables RV32M control codes 8-15.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  alu_ctrl,
    output logic        use_imm,
    output logic [31:0] imm,
    output logic        illegal,
    output lat_class_t  lat_class
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_shift_imm;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign is_shift_imm = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        alu_ctrl  = '0;
        use_imm   = 1'b0;
        imm       = '0;
        illegal   = 1'b1;
        lat_class = LAT_CLASS_I;
        case (opcode)
            OPC_OP: begin
                alu_ctrl = {instr[30], instr[25], funct3};
                if (alu_ctrl[4:3] == 2'b01) begin
`ifdef ALU_ISSUE_M_EXT_EN
                    illegal   = 1'b0;
                    lat_class = alu_ctrl[2] ? LAT_CLASS_DIV : LAT_CLASS_MUL;
`else
                    illegal   = 1'b1;
`endif
                end else begin
                    illegal = !is_rv32i_ctrl(alu_ctrl);
                end
            end
            OPC_OP_IMM: begin
                alu_ctrl = {(funct3 == 3'b101) ? instr[30] : 1'b0, 1'b0, funct3};
                use_imm  = 1'b1;
                // Shift-immediates carry the srai/srli selector in imm[10];
                // only the shamt field is handed to the ALU so b is the
                // actual shift amount.
                if (is_shift_imm)
                    imm = {27'd0, instr[24:20]};
                else
                    imm = {{20{instr[31]}}, instr[31:20]};
                illegal = !is_rv32i_ctrl(alu_ctrl);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: single-outstanding issue controller in front of an external ALU.
// Accepts one instruction, decodes it, drives the ALU with stable operands
// for the op's latency, captures the ALU result and presents it on a
// valid/ready output. Illegal instructions skip execution and report
// illegal=1 with result=0.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          instruction handshake
//   instr, rs1_val, rs2_val    instruction word and operands
//   alu_a, alu_b, alu_ctrl     ALU drive (held through EXEC)
//   alu_y                      ALU result
//   out_valid/out_ready        result handshake
//   result, illegal            captured result / illegal flag
// Configuration macro: ALU_ISSUE_M_EXT_EN enables multiply/divide ops with
// LAT_MUL/LAT_DIV latencies; when undefined they decode as illegal.
//
// state | meaning
// IDLE  | waiting for an instruction, in_ready=1
// EXEC  | ALU driven, latency counter running
// DONE  | result/illegal presented, waiting for out_ready
module alu_issue
    import alu_pkg::*;
#(
    parameter int LAT_I   = 1,
    parameter int LAT_MUL = 4,
    parameter int LAT_DIV = 34
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_ctrl,
    input  logic [31:0] alu_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        illegal
);

    localparam int LAT_MD  = (LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV;
    localparam int LAT_MAX = (LAT_I > LAT_MD) ? LAT_I : LAT_MD;
    localparam int CNT_W   = $clog2(LAT_MAX + 2);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   lat_load;
    logic               cnt_tc;
    logic               load_op;
    logic               cnt_dec;
    logic               capture;

    logic [4:0]         dec_ctrl;
    logic               dec_use_imm;
    logic [31:0]        dec_imm;
    logic               dec_illegal;
    lat_class_t         dec_lat;

    alu_decode u_decode (
        .instr     (instr),
        .alu_ctrl  (dec_ctrl),
        .use_imm   (dec_use_imm),
        .imm       (dec_imm),
        .illegal   (dec_illegal),
        .lat_class (dec_lat)
    );

    always_comb begin
        lat_load = CNT_W'(LAT_I);
        case (dec_lat)
`ifdef ALU_ISSUE_M_EXT_EN
            LAT_CLASS_MUL: lat_load = CNT_W'(LAT_MUL);
            LAT_CLASS_DIV: lat_load = CNT_W'(LAT_DIV);
`endif
            default: lat_load = CNT_W'(LAT_I);
        endcase
    end

    // Terminal count: the decrement that lands on zero is the capture cycle,
    // so y is sampled LAT cycles after the ALU is first driven. A latency of
    // zero still spends one cycle in EXEC.
    assign cnt_tc = (cnt == CNT_W'(1)) || (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load_op   = 1'b0;
        cnt_dec   = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_op   = 1'b1;
                    state_nxt = dec_illegal ? ST_DONE : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_tc) begin
                    capture   = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= '0;
            result   <= '0;
            illegal  <= 1'b0;
        end else if (load_op) begin
            alu_a    <= rs1_val;
            alu_b    <= dec_use_imm ? dec_imm : rs2_val;
            alu_ctrl <= dec_ctrl;
            cnt      <= lat_load;
            illegal  <= dec_illegal;
            result   <= '0;
        end else if (capture) begin
            result   <= alu_y;
            cnt      <= '0;
        end else if (cnt_dec) begin
            cnt      <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

    localparam int LAT_I   = 1;
    localparam int LAT_MUL = 4;
    localparam int LAT_DIV = 34;
`ifdef ALU_ISSUE_M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr, rs1_val, rs2_val;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [4:0]  alu_ctrl;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        illegal;

    alu_issue #(.LAT_I(LAT_I), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_y(alu_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [31:0] cyc = '0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] result;
        logic        illegal;
        int          lat;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  ctrl;
    } exp_t;

    exp_t        q[$];
    logic [31:0] acc_cyc = '0;
    int          cur_exp_lat = 0;
    logic [31:0] last_result;
    logic        last_illegal;
    bit          rdy_rand = 1'b0;

    // Behavioural ALU keyed on the RISC-V control code.
    function automatic logic [31:0] alu_fn(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        up;
        logic [31:0]        r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        r  = '0;
        case (c)
            5'd0:  r = a + b;
            5'd16: r = a - b;
            5'd1:  r = a << b[4:0];
            5'd5:  r = a >> b[4:0];
            5'd21: r = $signed(a) >>> b[4:0];
            5'd4:  r = a ^ b;
            5'd6:  r = a | b;
            5'd7:  r = a & b;
            5'd8:  begin up = {32'd0, a} * {32'd0, b}; r = up[31:0]; end
            5'd9:  begin sp = sa * sb; r = sp[63:32]; end
            5'd10: begin sp = sa * $signed({32'd0, b}); r = sp[63:32]; end
            5'd11: begin up = {32'd0, a} * {32'd0, b}; r = up[63:32]; end
            5'd12: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = $signed(a) / $signed(b);
            end
            5'd13: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd14: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
                else r = $signed(a) % $signed(b);
            end
            5'd15: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // External ALU stand-in: y is correct only in the cycle the issue block
    // should sample it, so early or late capture yields garbage.
    assign alu_y = ((cyc - acc_cyc) + 2 == cur_exp_lat) ? alu_fn(alu_ctrl, alu_a, alu_b)
                                                        : {16'hA5A5, cyc[15:0]};

    // Reference model: mnemonic-level decode from opcode/funct7/funct3.
    function automatic exp_t model(input string nm, input logic [31:0] ins,
                                   input logic [31:0] a, input logic [31:0] r2);
        exp_t e;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        opc = ins[6:0]; f7 = ins[31:25]; f3 = ins[14:12];
        e.name = nm; e.illegal = 1'b1; e.result = '0; e.lat = 1;
        e.a = a; e.b = r2; e.ctrl = '0;
        if (opc == 7'b0110011) begin
            if (f7 == 7'h00 && f3 != 3'd2 && f3 != 3'd3) begin
                e.ctrl = {2'b00, f3}; e.illegal = 1'b0; e.lat = LAT_I + 1;
            end else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
                e.ctrl = (f3 == 3'd0) ? 5'd16 : 5'd21; e.illegal = 1'b0; e.lat = LAT_I + 1;
            end else if (f7 == 7'h01 && M_EN) begin
                e.ctrl = 5'd8 + {2'b00, f3}; e.illegal = 1'b0;
                e.lat = (f3 < 3'd4) ? LAT_MUL + 1 : LAT_DIV + 1;
            end
        end else if (opc == 7'b0010011) begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
                e.b = {27'd0, ins[24:20]};
                e.ctrl = (f3 == 3'd5 && ins[30]) ? 5'd21 : {2'b00, f3};
                e.illegal = 1'b0; e.lat = LAT_I + 1;
            end else if (f3 != 3'd2 && f3 != 3'd3) begin
                e.b = {{20{ins[31]}}, ins[31:20]};
                e.ctrl = {2'b00, f3}; e.illegal = 1'b0; e.lat = LAT_I + 1;
            end
        end
        if (!e.illegal) e.result = alu_fn(e.ctrl, a, e.b);
        return e;
    endfunction

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [2:0] f3);
        return {imm, 5'd1, f3, 5'd3, 7'b0010011};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input string nm, input logic [31:0] ins,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk({nm, "_in_ready_timeout"}, {31'd0, in_ready}, 32'd1);
            return;
        end
        e = model(nm, ins, a, b);
        in_valid = 1'b1; instr = ins; rs1_val = a; rs2_val = b;
        @(posedge clk);
        #1;
        acc_cyc     = cyc;
        cur_exp_lat = e.lat;
        q.push_back(e);
        in_valid = 1'b0;
        instr    = $urandom;
        rs1_val  = $urandom;
        rs2_val  = $urandom;
    endtask

    task automatic drain(input string nm);
        int w;
        w = 0;
        while (q.size() > 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk({nm, "_drain"}, q.size(), 0);
        @(negedge clk);
    endtask

    // Monitor / scoreboard
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (q.size() > 0 && !in_ready && !out_valid) begin
                chk({q[0].name, "_alu_a"},    alu_a, q[0].a);
                chk({q[0].name, "_alu_b"},    alu_b, q[0].b);
                chk({q[0].name, "_alu_ctrl"}, {27'd0, alu_ctrl}, {27'd0, q[0].ctrl});
            end
            if (out_valid && !prev_ov) begin
                if (q.size() == 0)
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                else
                    chk({q[0].name, "_latency"}, (cyc - acc_cyc) + 1, q[0].lat);
            end
            if (out_valid && out_ready && q.size() > 0) begin
                chk({q[0].name, "_result"},  result, q[0].result);
                chk({q[0].name, "_illegal"}, {31'd0, illegal}, {31'd0, q[0].illegal});
                last_result  = result;
                last_illegal = illegal;
                void'(q.pop_front());
            end
            prev_ov = out_valid;
        end
    end

    always @(negedge clk) begin
        if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins, a, b;
        logic [2:0]  f3;
        logic [6:0]  f7s [3];
        int          kind;
        f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01;

        rst_n = 1'b0; in_valid = 1'b0; instr = '0; rs1_val = '0; rs2_val = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result",    result, 32'd0);
        chk("rst_illegal",   {31'd0, illegal}, 32'd0);
        chk("rst_alu_a",     alu_a, 32'd0);
        chk("rst_alu_b",     alu_b, 32'd0);
        chk("rst_alu_ctrl",  {27'd0, alu_ctrl}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        issue("add", r_type(7'h00, 3'b000), 32'd5, 32'd3);
        drain("add");
        chk("add_value", last_result, 32'd8);

        issue("sub", r_type(7'h20, 3'b000), 32'd3, 32'd5);
        drain("sub");
        chk("sub_value", last_result, 32'hFFFF_FFFE);

        issue("srai", i_type(12'h404, 3'b101), 32'h8000_0000, 32'h1234_5678);
        drain("srai");
        chk("srai_value", last_result, 32'hF800_0000);

        issue("mul", r_type(7'h01, 3'b000), 32'd7, 32'd6);
        drain("mul");
        chk("mul_value",   last_result, M_EN ? 32'd42 : 32'd0);
        chk("mul_illegal", {31'd0, last_illegal}, M_EN ? 32'd0 : 32'd1);

        // slt is illegal; hold the result under backpressure and try to
        // push another instruction while DONE.
        out_ready = 1'b0;
        issue("slt", r_type(7'h00, 3'b010), 32'd1, 32'd2);
        in_valid = 1'b1; instr = r_type(7'h00, 3'b000); rs1_val = 32'd1; rs2_val = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("slt_hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("slt_hold_in_ready",  {31'd0, in_ready},  32'd0);
            chk("slt_hold_illegal",   {31'd0, illegal},   32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("slt");

        // Reset in the middle of execution: nothing must be delivered.
        issue(M_EN ? "div_abort" : "add_abort",
              M_EN ? r_type(7'h01, 3'b100) : r_type(7'h00, 3'b000), 32'd100, 32'd7);
        if (M_EN) repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        chk("abort_out_valid_in_reset", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_result",    result, 32'd0);
        issue("add_after_abort", r_type(7'h00, 3'b000), 32'd5, 32'd3);
        drain("add_after_abort");
        chk("add_after_abort_value", last_result, 32'd8);

        rdy_rand = 1'b1;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            f3   = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if (kind <= 3) begin
                ins = r_type(f7s[$urandom_range(0, 2)], f3);
            end else if (kind <= 6) begin
                ins = i_type(12'($urandom), f3);
            end else if (kind == 7) begin
                ins = $urandom;
                if (ins[6:0] == 7'b0110011 || ins[6:0] == 7'b0010011) ins[6:0] = 7'b0000011;
            end else if (kind == 8) begin
                ins = i_type({($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, 5'($urandom)},
                             ($urandom_range(0, 1) != 0) ? 3'b101 : 3'b001);
            end else begin
                ins = r_type(7'h01, f3);
            end
            ins[11:7]  = 5'($urandom);
            ins[19:15] = 5'($urandom);
            if (ins[6:0] == 7'b0110011) ins[24:20] = 5'($urandom);
            issue("rand", ins, a, b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
